mem_arbiter: RTL and testbench

Shares one single-port synchronous RAM between the core's instruction-fetch port and its load/store port, so the split IRAM/RAM pair becomes one unified memory. Arbitrates per cycle: data port has priority, with a starvation guard for fetch. Returns read data one cycle after grant and tags it to the granted requester. Sits between pipelined_core and the shared ram instance. The core stalls on missing grant/rvalid.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_starve_counter.sv | 27 ++
 rtl/mem_arbiter.sv | 99 +++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// Owner encoding and starve-counter sizing.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_W = $clog2(STARVE_LIMIT_DEF + 1);

  function automatic int starve_w(input int lim);
    return $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter of consecutive denied fetch cycles.
// Clear wins over increment.
module starve_counter #(
  parameter int LIMIT = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  assign at_limit = (cnt == W'(LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one single-port RAM.
// Data wins unless fetch has been starved STARVE_LIMIT cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int SW = starve_w(STARVE_LIMIT);

  owner_e            owner_q;
  owner_e            owner_d;
  logic [SW-1:0]     starve_cnt;
  logic              force_i;
  logic [ADDR_W-1:0] addr_q;

  starve_counter #(
    .LIMIT(STARVE_LIMIT),
    .W    (SW)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc     (i_req && !i_gnt),
    .clr     (i_gnt || !i_req),
    .cnt     (starve_cnt),
    .at_limit(force_i)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Address is held while idle so the RAM pins do not toggle.
  always_ff @(posedge clk) begin
    if (i_gnt || d_gnt) begin
      addr_q <= mem_addr;
    end
  end

  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    owner_d   = OWN_NONE;
    mem_addr  = addr_q;
    mem_we    = '0;
    mem_wdata = d_wdata;
    if (!reset) begin
      if (d_req && !(i_req && force_i)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
    unique case (1'b1)
      d_gnt: begin
        owner_d  = OWN_D;
        mem_addr = d_addr;
        mem_we   = d_we;
      end
      i_gnt: begin
        owner_d  = OWN_I;
        mem_addr = i_addr;
      end
      default: owner_d = OWN_NONE;
    endcase
  end

  // Reset squashes the response of a grant from the previous cycle.
  assign i_rvalid = (owner_q == OWN_I) && !reset;
  assign d_rvalid = (owner_q == OWN_D) && !reset;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural RAM.
// Table vectors first, then randomized traffic against a model.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic [BW-1:0] d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int idx);
    return 32'hA500_0000 | 32'(idx);
  endfunction

  // RAM: registered read, byte-enabled write
  logic [31:0] ram    [256];
  bit          ram_wr [256];

  always @(posedge clk) begin : ram_blk
    logic [31:0] cur;
    int idx;
    idx = int'(mem_addr[9:2]);
    cur = ram_wr[idx] ? ram[idx] : init_word(idx);
    mem_rdata <= cur;
    if (mem_we != '0) begin
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
      ram[idx]    <= cur;
      ram_wr[idx] <= 1'b1;
    end
  end

  // Reference model state
  logic [31:0] shadow [256];
  bit          sh_wr  [256];
  int          starve = 0;
  bit          pend_v = 0;
  bit          pend_d = 0;
  bit          pend_load = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] last_addr = '0;
  bit          last_known = 0;

  int cmp_n = 0;
  int err_n = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sh_rd(input int idx);
    return sh_wr[idx] ? shadow[idx] : init_word(idx);
  endfunction

  task automatic step(input bit rst, input bit ir, input logic [31:0] ia,
                      input bit dr, input logic [3:0] dwe,
                      input logic [31:0] da, input logic [31:0] dwd,
                      input bit use_tbl, input bit eig, input bit edg,
                      input bit chk_rd, input logic [31:0] erd);
    bit mg_i, mg_d, ev_i, ev_d;
    logic [31:0] a, cur;
    int idx;
    reset   = rst;
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
    @(negedge clk);
    mg_i = 0;
    mg_d = 0;
    if (!rst) begin
      if (dr && ir) begin
        if (starve == LIM) mg_i = 1;
        else mg_d = 1;
      end else begin
        mg_d = dr;
        mg_i = ir;
      end
    end
    if (use_tbl) begin
      chk("tbl_i_gnt", 32'(i_gnt), 32'(eig));
      chk("tbl_d_gnt", 32'(d_gnt), 32'(edg));
    end
    chk("i_gnt", 32'(i_gnt), 32'(mg_i));
    chk("d_gnt", 32'(d_gnt), 32'(mg_d));
    ev_i = pend_v && !pend_d && !rst;
    ev_d = pend_v && pend_d && !rst;
    chk("i_rvalid", 32'(i_rvalid), 32'(ev_i));
    chk("d_rvalid", 32'(d_rvalid), 32'(ev_d));
    if (ev_i) chk("i_rdata", i_rdata, pend_data);
    if (ev_d && pend_load) chk("d_rdata", d_rdata, pend_data);
    if (chk_rd) chk("tbl_rdata", pend_d ? d_rdata : i_rdata, erd);
    chk("mem_we", 32'(mem_we), mg_d ? 32'(dwe) : 32'd0);
    if (mg_d) chk("mem_addr", mem_addr, da);
    else if (mg_i) chk("mem_addr", mem_addr, ia);
    else if (last_known) chk("mem_addr_hold", mem_addr, last_addr);
    if (mg_d && dwe != 0) chk("mem_wdata", mem_wdata, dwd);
    @(posedge clk);
    if (rst) begin
      pend_v = 0;
      starve = 0;
    end else begin
      pend_v    = mg_i || mg_d;
      pend_d    = mg_d;
      pend_load = mg_i || (dwe == 0);
      if (pend_v) begin
        a = mg_d ? da : ia;
        idx = int'(a[9:2]);
        pend_data = sh_rd(idx);
        if (mg_d && dwe != 0) begin
          cur = pend_data;
          for (int b = 0; b < BW; b++)
            if (dwe[b]) cur[8*b +: 8] = dwd[8*b +: 8];
          shadow[idx] = cur;
          sh_wr[idx]  = 1;
        end
        last_addr  = a;
        last_known = 1;
      end
      if (ir && !mg_i) starve = (starve < LIM) ? starve + 1 : LIM;
      else starve = 0;
    end
    #1;
  endtask

  typedef struct {
    bit          rst;
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    logic [3:0]  dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    bit          eig;
    bit          edg;
    bit          chk_rd;
    logic [31:0] erd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit ir, logic [31:0] ia, bit dr,
                              logic [3:0] dwe, logic [31:0] da,
                              logic [31:0] dwd, bit eig, bit edg,
                              bit chk_rd, logic [31:0] erd);
    vec_t v;
    v = '{rst, ir, ia, dr, dwe, da, dwd, eig, edg, chk_rd, erd};
    return v;
  endfunction

  initial begin
    reset   = 1;
    i_req   = 0;
    i_addr  = '0;
    d_req   = 0;
    d_we    = '0;
    d_addr  = '0;
    d_wdata = '0;
    @(posedge clk);
    #1;
    // reset holds grants and writes off
    tbl.push_back(mk(1, 1, 0, 1, 4'hF, 32'h10, 32'h1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 4'hF, 32'h10, 32'h1, 0, 0, 0, 0));
    // fetch only
    tbl.push_back(mk(0, 1, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h4, 0, 0, 0, 0, 1, 0, 1, 32'hA500_0000));
    tbl.push_back(mk(0, 1, 32'h8, 0, 0, 0, 0, 1, 0, 1, 32'hA500_0001));
    tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 32'hA500_0002));
    // store, load, byte store, reload
    tbl.push_back(mk(0, 0, 0, 1, 4'hF, 32'h100, 32'hDEADBEEF, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'h0, 32'h100, 32'h0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0, 1, 4'h2, 32'h100, 32'h0000AB00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 4'h0, 32'h100, 32'h0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 32'hDEADABEF));
    // contention: D,D,D,D,I repeating
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 1, 32'h20, 1, 0, 32'h40, 0,
                       (k % 5) == 4, (k % 5) != 4, 0, 0));
    // reset right after a load grant
    tbl.push_back(mk(0, 0, 0, 1, 4'h0, 32'h100, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    // counter restarted from zero
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 1, 32'h24, 1, 0, 32'h44, 0,
                       k == 4, k != 4, 0, 0));
    // idle: address held, nothing granted
    tbl.push_back(mk(0, 0, 32'h3C, 0, 4'hF, 32'h38, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 32'h3C, 0, 4'hF, 32'h38, 0, 0, 0, 0, 0));

    foreach (tbl[n])
      step(tbl[n].rst, tbl[n].ir, tbl[n].ia, tbl[n].dr, tbl[n].dwe,
           tbl[n].da, tbl[n].dwd, 1, tbl[n].eig, tbl[n].edg,
           tbl[n].chk_rd, tbl[n].erd);

    for (int n = 0; n < 600; n++) begin
      bit rst, ir, dr;
      logic [3:0] dwe;
      logic [31:0] ia, da, dwd;
      rst = ($urandom_range(0, 49) == 0);
      ir  = ($urandom_range(0, 3) != 0);
      dr  = ($urandom_range(0, 2) != 0);
      ia  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      da  = {22'd0, 8'($urandom_range(0, 31)), 2'b00};
      dwd = $urandom;
      dwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(rst, ir, ia, dr, dwe, da, dwd, 0, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
